// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the register-file write-port arbiter:
//   register file geometry, the arbiter state encoding and the
//   hardwired-zero register address.
package regfile_pkg;

    localparam int ADDR_W = 5;   // register address width
    localparam int DATA_W = 32;  // register data width
    localparam int NREG   = 32;  // registers cleared by the reset sweep

    // Address of the hardwired zero register; writes to it are accepted
    // but never reach the register file.
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        CLEAR = 1'b0,  // sweeping zeros into the register file
        RUN   = 1'b1   // arbitrating writeback requests
    } state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// rr_arbiter2
//   Two-way round-robin grant. A lone requester always wins; when both
//   request, the port that did not win last time gets the grant.
// Ports:
//   req[1:0]    request from port 0 / port 1
//   last_grant  index of the port that won the most recent transfer
//   enable      0 forces both grants low
//   gnt[1:0]    one-hot grant (or zero)
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = last_grant ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Sole owner of the register file write port (A3/WE3/WD3). After every
//   reset it writes zero to registers 0..NREG-1, one per cycle, then
//   shares the port between two writeback requesters with round-robin
//   arbitration. Writes are registered: a transfer accepted in cycle N
//   appears on rf_we3 in cycle N+1.
//
// Handshake: wrN_ready is high when the block is in RUN and port N holds
//   the grant; it depends combinationally on both valids. A transfer
//   happens in a cycle where wrN_valid && wrN_ready. Requesters must not
//   derive valid from ready and must hold valid/addr/data until accepted.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wrN_valid/addr/data   write request from requester N (N = 0, 1)
//   wrN_ready             request from N accepted this cycle
//   rf_a3/rf_we3/rf_wd3   register file write port
//   init_done             clear sweep complete
//   stat_clr              zero the stall counter
//   stall_cnt             saturating count of cycles with a waiting requester
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int NREG   = regfile_pkg::NREG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr0_valid,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    output logic [ADDR_W-1:0] rf_a3,
    output logic              rf_we3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              init_done,
    input  logic              stat_clr,
    output logic [15:0]       stall_cnt
);

    localparam logic [ADDR_W-1:0] LAST_SWEEP = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(ZERO_REG);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] rf_a3_q, rf_a3_d;
    logic              rf_we3_q, rf_we3_d;
    logic [DATA_W-1:0] rf_wd3_q, rf_wd3_d;
    logic              init_done_q, init_done_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic [1:0] gnt;
    logic       xfer0;
    logic       xfer1;
    logic       stalled;

    rr_arbiter2 u_rr (
        .req        ({wr1_valid, wr0_valid}),
        .last_grant (last_grant_q),
        .enable     (state_q == RUN),
        .gnt        (gnt)
    );

    assign wr0_ready = gnt[0];
    assign wr1_ready = gnt[1];
    assign xfer0     = wr0_valid && wr0_ready;
    assign xfer1     = wr1_valid && wr1_ready;
    assign stalled   = (wr0_valid && !wr0_ready) || (wr1_valid && !wr1_ready);

    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        last_grant_d = last_grant_q;
        rf_a3_d      = rf_a3_q;
        rf_we3_d     = 1'b0;
        rf_wd3_d     = rf_wd3_q;
        init_done_d  = init_done_q;
        stall_cnt_d  = stall_cnt_q;

        case (state_q)
            CLEAR: begin
                rf_a3_d      = sweep_addr_q;
                rf_we3_d     = 1'b1;
                rf_wd3_d     = '0;
                sweep_addr_d = sweep_addr_q + 1'b1;
                if (sweep_addr_q == LAST_SWEEP) begin
                    state_d      = RUN;
                    init_done_d  = 1'b1;
                    sweep_addr_d = '0;
                end
            end
            RUN: begin
                // The zero register accepts the transfer but suppresses WE3.
                if (xfer0) begin
                    rf_a3_d      = wr0_addr;
                    rf_wd3_d     = wr0_data;
                    rf_we3_d     = (wr0_addr != ZERO_ADDR);
                    last_grant_d = 1'b0;
                end else if (xfer1) begin
                    rf_a3_d      = wr1_addr;
                    rf_wd3_d     = wr1_data;
                    rf_we3_d     = (wr1_addr != ZERO_ADDR);
                    last_grant_d = 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        if (stat_clr) begin
            stall_cnt_d = '0;
        end else if (state_q == RUN && stalled && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            sweep_addr_q <= '0;
            last_grant_q <= 1'b1;  // port 0 wins the first contest
            rf_a3_q      <= '0;
            rf_we3_q     <= 1'b0;
            rf_wd3_q     <= '0;
            init_done_q  <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            last_grant_q <= last_grant_d;
            rf_a3_q      <= rf_a3_d;
            rf_we3_q     <= rf_we3_d;
            rf_wd3_q     <= rf_wd3_d;
            init_done_q  <= init_done_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign rf_a3     = rf_a3_q;
    assign rf_we3    = rf_we3_q;
    assign rf_wd3    = rf_wd3_q;
    assign init_done = init_done_q;
    assign stall_cnt = stall_cnt_q;

endmodule
